// File: rtl/ped_signal_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ped_signal_ctrl_pkg : state type, lamp codes and one-hot helper
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package ped_signal_ctrl_pkg;

  typedef enum logic [1:0] {
    STOP  = 2'd0,
    WALK  = 2'd1,
    CLEAR = 2'd2,
    FAULT = 2'd3
  } ped_state_t;

  // Lamp encoding shared with the vehicle controller
  localparam logic [1:0] RED    = 2'b00;
  localparam logic [1:0] YELLOW = 2'b01;
  localparam logic [1:0] GREEN  = 2'b10;

  function automatic logic is_one_hot3(input logic [2:0] v);
    return (v == 3'b001) || (v == 3'b010) || (v == 3'b100);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ped_signal_ctrl_btn_sync_edge.sv
// ---------------------------------------------------------------------------
// btn_sync_edge : 2-flop synchroniser plus registered rising-edge pulse
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module btn_sync_edge (
  input  logic clock,
  input  logic reset,
  input  logic btn,
  output logic rise
);

  logic [2:0] sync;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync <= 3'b000;
      rise <= 1'b0;
    end else begin
      sync <= {sync[1:0], btn};
      rise <= sync[1] & ~sync[2];
    end
  end

endmodule

`default_nettype wire

// File: rtl/ped_signal_ctrl.sv
// ---------------------------------------------------------------------------
// ped_signal_ctrl : pedestrian WALK/CLEAR sequencer slaved to vehicle red
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ped_signal_ctrl
  import ped_signal_ctrl_pkg::*;
#(
  parameter int WALK_T     = 12,
  parameter int CLEAR_T    = 14,
  parameter int BLINK_HALF = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       r,
  input  logic       y,
  input  logic       g,
  input  logic       ped_btn,
  output logic       walk,
  output logic       dont_walk,
  output logic [4:0] countdown,
  output logic       req_pending,
  output logic       overrun,
  output logic       fault
);

  localparam logic [4:0] WALK_LOAD  = 5'(WALK_T - 1);
  localparam logic [4:0] CLEAR_LOAD = 5'(CLEAR_T - 1);
  localparam logic [4:0] BLINK_LOAD = 5'(BLINK_HALF - 1);

  ped_state_t state, state_nx;
  logic [4:0] timer, timer_nx;
  logic [4:0] blink_cnt, blink_cnt_nx;
  logic       blink_lvl, blink_lvl_nx;
  logic       r_q, bad_q;
  logic       btn_rise, red_rise, bad;
  logic       req_nx, overrun_nx;

  btn_sync_edge u_btn (
    .clock (clock),
    .reset (reset),
    .btn   (ped_btn),
    .rise  (btn_rise)
  );

  assign red_rise = r & ~r_q;
  assign bad      = ~is_one_hot3({r, y, g});

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= STOP;
      timer     <= 5'd0;
      blink_cnt <= 5'd0;
      blink_lvl <= 1'b1;
      r_q       <= 1'b0;
      bad_q     <= 1'b0;
    end else begin
      state     <= state_nx;
      timer     <= timer_nx;
      blink_cnt <= blink_cnt_nx;
      blink_lvl <= blink_lvl_nx;
      r_q       <= r;
      bad_q     <= bad;
    end
  end

  always_comb begin
    state_nx     = state;
    timer_nx     = timer;
    blink_cnt_nx = blink_cnt;
    blink_lvl_nx = blink_lvl;
    req_nx       = req_pending;
    overrun_nx   = overrun;
    case (state)
      STOP: begin
        if (btn_rise) req_nx = 1'b1;
        // A press arriving on the same cycle as red_rise is served immediately
        if (red_rise && (req_pending || btn_rise)) begin
          state_nx = WALK;
          timer_nx = WALK_LOAD;
          req_nx   = 1'b0;
        end
      end
      WALK: begin
        if (!r) begin
          state_nx   = STOP;
          overrun_nx = 1'b1;
        end else if (timer == 5'd0) begin
          state_nx     = CLEAR;
          timer_nx     = CLEAR_LOAD;
          blink_cnt_nx = BLINK_LOAD;
          blink_lvl_nx = 1'b1;
        end else begin
          timer_nx = timer - 5'd1;
        end
      end
      CLEAR: begin
        if (!r) begin
          state_nx   = STOP;
          overrun_nx = 1'b1;
        end else if (timer == 5'd0) begin
          state_nx = STOP;
        end else begin
          timer_nx = timer - 5'd1;
          if (blink_cnt == 5'd0) begin
            blink_cnt_nx = BLINK_LOAD;
            blink_lvl_nx = ~blink_lvl;
          end else begin
            blink_cnt_nx = blink_cnt - 5'd1;
          end
        end
      end
      FAULT: begin
        state_nx = FAULT;
      end
      default: begin
        state_nx = FAULT;
      end
    endcase
    // Two consecutive non-one-hot lamp cycles trump everything else
    if (bad && bad_q) begin
      state_nx   = FAULT;
      req_nx     = req_pending;
      overrun_nx = overrun;
    end
  end

  // Outputs decode the next state so they line up with the state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      walk        <= 1'b0;
      dont_walk   <= 1'b1;
      countdown   <= 5'd0;
      req_pending <= 1'b0;
      overrun     <= 1'b0;
      fault       <= 1'b0;
    end else begin
      walk        <= (state_nx == WALK);
      dont_walk   <= (state_nx == CLEAR) ? blink_lvl_nx : (state_nx != WALK);
      countdown   <= (state_nx == CLEAR) ? (timer_nx + 5'd1) : 5'd0;
      req_pending <= req_nx;
      overrun     <= overrun_nx;
      fault       <= fault | (state_nx == FAULT);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ped_signal_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ped_signal_ctrl : directed self-checking bench for ped_signal_ctrl
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_ped_signal_ctrl;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       r = 1'b0, y = 1'b0, g = 1'b1;
  logic       ped_btn = 1'b0;
  logic       walk, dont_walk, req_pending, overrun, fault;
  logic [4:0] countdown;

  int checks = 0;
  int errors = 0;

  ped_signal_ctrl #(
    .WALK_T     (12),
    .CLEAR_T    (14),
    .BLINK_HALF (2)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .r           (r),
    .y           (y),
    .g           (g),
    .ped_btn     (ped_btn),
    .walk        (walk),
    .dont_walk   (dont_walk),
    .countdown   (countdown),
    .req_pending (req_pending),
    .overrun     (overrun),
    .fault       (fault)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic lamps(input logic rr, input logic yy, input logic gg);
    r = rr;
    y = yy;
    g = gg;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk5(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_lamps(input string tag, input logic ew, input logic edw, input logic [4:0] ecd);
    chk1({tag, ".walk"}, walk, ew);
    chk1({tag, ".dont_walk"}, dont_walk, edw);
    chk5({tag, ".countdown"}, countdown, ecd);
  endtask

  task automatic run_idle(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      step();
      chk_lamps($sformatf("%s%0d", tag, i), 1'b0, 1'b1, 5'd0);
    end
  endtask

  initial begin
    // Reset state
    steps(2);
    chk_lamps("reset", 1'b0, 1'b1, 5'd0);
    chk1("reset.req", req_pending, 1'b0);
    chk1("reset.overrun", overrun, 1'b0);
    chk1("reset.fault", fault, 1'b0);
    reset = 1'b0;
    step();

    // 1: press during green, served at the next red
    ped_btn = 1'b1;
    steps(3);
    chk1("t1_req_early", req_pending, 1'b0);
    step();
    chk1("t1_req_set", req_pending, 1'b1);
    step();
    ped_btn = 1'b0;
    steps(3);
    lamps(1'b0, 1'b1, 1'b0);
    steps(2);
    chk_lamps("t1_yellow", 1'b0, 1'b1, 5'd0);
    chk1("t1_req_hold", req_pending, 1'b1);
    lamps(1'b1, 1'b0, 1'b0);
    step();
    chk_lamps("t1_walk1", 1'b1, 1'b0, 5'd0);
    chk1("t1_req_clr", req_pending, 1'b0);
    for (int i = 2; i <= 12; i++) begin
      step();
      chk_lamps($sformatf("t1_walk%0d", i), 1'b1, 1'b0, 5'd0);
    end
    for (int k = 1; k <= 14; k++) begin
      step();
      chk_lamps($sformatf("t1_clear%0d", k), 1'b0, (((k - 1) / 2) % 2) == 0, 5'(15 - k));
    end
    step();
    chk_lamps("t1_stop", 1'b0, 1'b1, 5'd0);
    chk1("t1_stop.req", req_pending, 1'b0);
    chk1("t1_stop.overrun", overrun, 1'b0);

    // 2: full vehicle cycle without a press
    run_idle("t2_red", 3);
    lamps(1'b0, 1'b0, 1'b1);
    run_idle("t2_green", 10);
    lamps(1'b0, 1'b1, 1'b0);
    run_idle("t2_yellow", 3);
    lamps(1'b1, 1'b0, 1'b0);
    run_idle("t2_red2_", 5);

    // 3: press mid-red waits for the next red_rise
    ped_btn = 1'b1;
    steps(2);
    ped_btn = 1'b0;
    steps(4);
    chk1("t3_req_set", req_pending, 1'b1);
    run_idle("t3_red", 5);
    lamps(1'b0, 1'b0, 1'b1);
    run_idle("t3_green", 4);
    lamps(1'b0, 1'b1, 1'b0);
    run_idle("t3_yellow", 2);
    lamps(1'b1, 1'b0, 1'b0);
    step();
    chk_lamps("t3_walk1", 1'b1, 1'b0, 5'd0);

    // 4: red drops in CLEAR cycle 5
    steps(11);
    chk_lamps("t4_walk12", 1'b1, 1'b0, 5'd0);
    steps(5);
    chk_lamps("t4_clear5", 1'b0, 1'b1, 5'd10);
    lamps(1'b0, 1'b0, 1'b1);
    step();
    chk_lamps("t4_stop", 1'b0, 1'b1, 5'd0);
    chk1("t4_overrun", overrun, 1'b1);
    steps(5);
    chk1("t4_overrun_sticky", overrun, 1'b1);

    // 5: one-hot check
    lamps(1'b1, 1'b0, 1'b1);
    step();
    lamps(1'b0, 1'b0, 1'b1);
    steps(2);
    chk1("t5_glitch_ok", fault, 1'b0);
    lamps(1'b1, 1'b0, 1'b1);
    step();
    chk1("t5_one_bad", fault, 1'b0);
    step();
    chk1("t5_fault", fault, 1'b1);
    chk_lamps("t5_fault", 1'b0, 1'b1, 5'd0);
    lamps(1'b0, 1'b0, 1'b1);
    ped_btn = 1'b1;
    steps(6);
    ped_btn = 1'b0;
    chk1("t5_req_ignored", req_pending, 1'b0);
    lamps(1'b1, 1'b0, 1'b0);
    step();
    chk_lamps("t5_red", 1'b0, 1'b1, 5'd0);
    steps(3);
    chk1("t5_fault_sticky", fault, 1'b1);
    chk1("t5_walk", walk, 1'b0);

    // 6: asynchronous reset mid-WALK
    reset = 1'b1;
    step();
    chk1("t6_clr.fault", fault, 1'b0);
    chk1("t6_clr.overrun", overrun, 1'b0);
    reset = 1'b0;
    lamps(1'b0, 1'b0, 1'b1);
    ped_btn = 1'b1;
    steps(5);
    ped_btn = 1'b0;
    chk1("t6_req", req_pending, 1'b1);
    lamps(1'b1, 1'b0, 1'b0);
    step();
    chk1("t6_walk1", walk, 1'b1);
    steps(4);
    chk1("t6_walk5", walk, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk_lamps("t6_async", 1'b0, 1'b1, 5'd0);
    chk1("t6_async.req", req_pending, 1'b0);
    chk1("t6_async.fault", fault, 1'b0);
    step();
    reset = 1'b0;
    step();
    chk_lamps("t6_after", 1'b0, 1'b1, 5'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
